// File: rtl/pll_reconfig_seq.sv
// Runtime PLL reconfiguration sequencer: captures M/N/C/K settings, writes them over Avalon-MM,
// triggers reconfiguration and supervises relock. Define PLL_RECFG_FRAC_EN to enable the K (fractional) write.
module pll_reconfig_seq #(
  parameter int unsigned NUM_CLOCKS   = 1,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic                       refclk,
  input  logic                       rst_n,
  input  logic                       cfg_start,
  input  logic [17:0]                cfg_m,
  input  logic [17:0]                cfg_n,
  input  logic [18*NUM_CLOCKS-1:0]   cfg_c,
  input  logic [31:0]                cfg_k,
  output logic                       cfg_busy,
  output logic                       cfg_done,
  output logic                       cfg_error,
  output logic                       lock_lost,
  output logic [5:0]                 mgmt_address,
  output logic                       mgmt_write,
  output logic [31:0]                mgmt_writedata,
  input  logic                       mgmt_waitrequest,
  input  logic                       pll_locked
);

  typedef enum logic [3:0] {
    S_IDLE, S_MODE, S_WR_M, S_WR_N, S_WR_C, S_WR_K,
    S_START, S_GUARD, S_WAIT_LOCK, S_DONE, S_ERROR
  } state_t;

  localparam logic [4:0]  LAST_IDX     = 5'(NUM_CLOCKS - 1);
  localparam logic [15:0] GUARD_LAST   = 16'(GUARD_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);

  state_t                    state, state_nx;
  logic [17:0]               m_q, n_q;
  logic [18*NUM_CLOCKS-1:0]  c_q;
  logic [4:0]                idx;
  logic [15:0]               cnt;
  logic                      locked_q, armed;
  logic                      accept, lock_fall;

`ifdef PLL_RECFG_FRAC_EN
  logic [31:0]               k_q;
`else
  logic                      unused_k;
  assign unused_k = ^cfg_k;
`endif

  assign accept    = (state == S_IDLE) && cfg_start;
  assign lock_fall = (state == S_IDLE) && armed && locked_q && !pll_locked;
  assign cfg_busy  = (state != S_IDLE);
  assign cfg_done  = (state == S_DONE);

  always_comb begin
    state_nx       = state;
    mgmt_write     = 1'b0;
    mgmt_address   = '0;
    mgmt_writedata = '0;
    case (state)
      S_IDLE: if (cfg_start) state_nx = S_MODE;
      S_MODE: begin
        mgmt_write   = 1'b1;
        mgmt_address = 6'h00;
        if (!mgmt_waitrequest) state_nx = S_WR_M;
      end
      S_WR_M: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'h04;
        mgmt_writedata = {14'b0, m_q};
        if (!mgmt_waitrequest) state_nx = S_WR_N;
      end
      S_WR_N: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'h03;
        mgmt_writedata = {14'b0, n_q};
        if (!mgmt_waitrequest) state_nx = S_WR_C;
      end
      // c_q shifts down after each accepted C write, so the current word is always at the bottom
      S_WR_C: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'h05;
        mgmt_writedata = {9'b0, idx, c_q[17:0]};
        if (!mgmt_waitrequest && idx == LAST_IDX) begin
`ifdef PLL_RECFG_FRAC_EN
          state_nx = S_WR_K;
`else
          state_nx = S_START;
`endif
        end
      end
      S_WR_K: begin
`ifdef PLL_RECFG_FRAC_EN
        mgmt_write     = 1'b1;
        mgmt_address   = 6'h07;
        mgmt_writedata = k_q;
        if (!mgmt_waitrequest) state_nx = S_START;
`else
        state_nx = S_START;
`endif
      end
      S_START: begin
        mgmt_write   = 1'b1;
        mgmt_address = 6'h02;
        if (!mgmt_waitrequest) state_nx = S_GUARD;
      end
      S_GUARD: if (cnt == GUARD_LAST) state_nx = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (pll_locked)               state_nx = S_DONE;
        else if (cnt == TIMEOUT_LAST) state_nx = S_ERROR;
      end
      S_DONE:  state_nx = S_IDLE;
      S_ERROR: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      m_q       <= '0;
      n_q       <= '0;
      c_q       <= '0;
      idx       <= '0;
      cnt       <= '0;
      locked_q  <= 1'b0;
      armed     <= 1'b0;
      cfg_error <= 1'b0;
      lock_lost <= 1'b0;
`ifdef PLL_RECFG_FRAC_EN
      k_q       <= '0;
`endif
    end else begin
      state    <= state_nx;
      locked_q <= pll_locked;
      cnt      <= (state_nx != state || state == S_IDLE) ? '0 : cnt + 16'd1;

      // an accepted start takes priority over a simultaneous lock-monitor fall
      if (accept) begin
        m_q       <= cfg_m;
        n_q       <= cfg_n;
        c_q       <= cfg_c;
        idx       <= '0;
        cfg_error <= 1'b0;
        lock_lost <= 1'b0;
        armed     <= 1'b0;
`ifdef PLL_RECFG_FRAC_EN
        k_q       <= cfg_k;
`endif
      end else if (lock_fall) begin
        lock_lost <= 1'b1;
        armed     <= 1'b0;
      end

      if (state == S_WR_C && !mgmt_waitrequest) begin
        idx <= idx + 5'd1;
        c_q <= c_q >> 18;
      end

      if (state == S_DONE) armed <= 1'b1;
      if (state == S_WAIT_LOCK && state_nx == S_ERROR) begin
        cfg_error <= 1'b1;
        armed     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Scoreboard bench for pll_reconfig_seq (NUM_CLOCKS=2, LOCK_TIMEOUT=100); follows PLL_RECFG_FRAC_EN if defined.
`timescale 1ns/1ps
module tb_pll_reconfig_seq;

  localparam int unsigned NCLK = 2;
  localparam int unsigned TMO  = 100;
  localparam int unsigned GRD  = 16;
`ifdef PLL_RECFG_FRAC_EN
  localparam int KW = 1;
`else
  localparam int KW = 0;
`endif
  localparam int S_REL = 4 + NCLK + KW;   // START write cycle relative to the accepted start

  logic              refclk, rst_n, cfg_start;
  logic [17:0]       cfg_m, cfg_n;
  logic [18*NCLK-1:0] cfg_c;
  logic [31:0]       cfg_k;
  logic              cfg_busy, cfg_done, cfg_error, lock_lost;
  logic [5:0]        mgmt_address;
  logic              mgmt_write;
  logic [31:0]       mgmt_writedata;
  logic              mgmt_waitrequest, pll_locked;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    int          at;
  } wr_t;
  wr_t sb[$];
  wr_t e;

  pll_reconfig_seq #(.NUM_CLOCKS(NCLK), .LOCK_TIMEOUT(TMO), .GUARD_CYCLES(GRD)) dut (
    .refclk(refclk), .rst_n(rst_n), .cfg_start(cfg_start),
    .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_c(cfg_c), .cfg_k(cfg_k),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_error(cfg_error), .lock_lost(lock_lost),
    .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_writedata(mgmt_writedata),
    .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked)
  );

  initial refclk = 1'b0;
  always #10 refclk = ~refclk;
  always @(posedge refclk) cyc <= cyc + 1;

  // accepted writes are popped against the scoreboard
  always @(negedge refclk) begin
    if (rst_n && mgmt_write && !mgmt_waitrequest) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h cycle=%0d, expected no write",
                 mgmt_address, mgmt_writedata, cyc);
      end else begin
        e = sb.pop_front();
        if (mgmt_address !== e.addr || mgmt_writedata !== e.data || cyc != e.at) begin
          errors++;
          $display("FAIL write: got addr=%h data=%h cycle=%0d, expected addr=%h data=%h cycle=%0d",
                   mgmt_address, mgmt_writedata, cyc, e.addr, e.data, e.at);
        end
      end
    end
  end

  function automatic wr_t mk(input logic [5:0] a, input logic [31:0] d, input int t);
    wr_t w;
    w.addr = a;
    w.data = d;
    w.at   = t;
    return w;
  endfunction

  task automatic push_writes(input int base, input int st);
    sb.push_back(mk(6'h00, 32'h0, base + 1));
    sb.push_back(mk(6'h04, {14'b0, cfg_m}, base + 2));
    sb.push_back(mk(6'h03, {14'b0, cfg_n}, base + 3 + st));
    for (int i = 0; i < NCLK; i++)
      sb.push_back(mk(6'h05, {9'b0, 5'(i), cfg_c[18*i +: 18]}, base + 4 + st + i));
`ifdef PLL_RECFG_FRAC_EN
    sb.push_back(mk(6'h07, cfg_k, base + 4 + NCLK + st));
`endif
    sb.push_back(mk(6'h02, 32'h0, base + S_REL + st));
  endtask

  task automatic start_cfg(output int base);
    @(posedge refclk); #1;
    cfg_start = 1'b1;
    base = cyc;
    @(posedge refclk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_cycle(input int target);
    for (int i = 0; i < 100000 && cyc < target; i++) begin
      @(posedge refclk); #1;
    end
  endtask

  task automatic wait_end(input int budget, output int at, output logic d, output logic er);
    at = -1; d = 1'b0; er = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge refclk);
      if (cfg_done || (cfg_error && cfg_busy)) begin
        at = cyc; d = cfg_done; er = cfg_error;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cfg_start = 1'b0; mgmt_waitrequest = 1'b0; pll_locked = 1'b1;
    cfg_m = '0; cfg_n = '0; cfg_c = '0; cfg_k = '0;
    repeat (3) @(posedge refclk);
    #1 rst_n = 1'b1;
    @(negedge refclk);
    checks++;
    if ({cfg_busy, cfg_done, cfg_error, lock_lost, mgmt_write} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000", {cfg_busy, cfg_done, cfg_error, lock_lost, mgmt_write});
    end
    checks++;
    if (mgmt_address !== 6'h0) begin
      errors++; $display("FAIL reset_addr: got %h expected 00", mgmt_address);
    end
    checks++;
    if (mgmt_writedata !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", mgmt_writedata);
    end
  endtask

  task automatic test_basic;
    int base, at;
    logic d, er;
    cfg_m = 18'h00808; cfg_n = 18'h10000; cfg_c = {18'h00505, 18'h00303}; cfg_k = 32'h8000_0000;
    pll_locked = 1'b1;
    start_cfg(base);
    push_writes(base, 0);
    @(negedge refclk);
    checks++;
    if (cfg_busy !== 1'b1) begin errors++; $display("FAIL busy_cycle1: got %b expected 1", cfg_busy); end
    // inputs and a second start during busy must not disturb the sequence
    @(posedge refclk); #1;
    cfg_m = 18'h3ffff; cfg_n = 18'h00001; cfg_c = '1; cfg_k = 32'h0; cfg_start = 1'b1;
    @(posedge refclk); #1;
    cfg_start = 1'b0;
    wait_end(200, at, d, er);
    checks++;
    if (at != base + S_REL + GRD + 2 || d !== 1'b1 || er !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: got cycle=%0d done=%b err=%b expected cycle=%0d done=1 err=0",
               at, d, er, base + S_REL + GRD + 2);
    end
    @(negedge refclk);
    checks++;
    if (cfg_busy !== 1'b0 || cfg_done !== 1'b0) begin
      errors++; $display("FAIL basic_after: got busy=%b done=%b expected 0 0", cfg_busy, cfg_done);
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL basic_sb: got %0d pending expected 0", sb.size()); end
    cfg_m = 18'h00808; cfg_n = 18'h10000; cfg_c = {18'h00505, 18'h00303}; cfg_k = 32'h8000_0000;
  endtask

  task automatic test_lock_lost;
    @(posedge refclk); #1 pll_locked = 1'b0;
    @(negedge refclk);
    @(negedge refclk);
    checks++;
    if (lock_lost !== 1'b1) begin errors++; $display("FAIL lock_lost_set: got %b expected 1", lock_lost); end
    @(posedge refclk); #1 pll_locked = 1'b1;
    repeat (5) @(negedge refclk);
    checks++;
    if (lock_lost !== 1'b1 || cfg_busy !== 1'b0) begin
      errors++; $display("FAIL lock_lost_sticky: got lost=%b busy=%b expected 1 0", lock_lost, cfg_busy);
    end
  endtask

  task automatic test_timeout;
    int base, at;
    logic d, er;
    pll_locked = 1'b0;
    start_cfg(base);
    push_writes(base, 0);
    @(negedge refclk);
    checks++;
    if (lock_lost !== 1'b0) begin errors++; $display("FAIL lost_cleared: got %b expected 0", lock_lost); end
    wait_end(300, at, d, er);
    checks++;
    if (at != base + S_REL + GRD + 1 + TMO || d !== 1'b0 || er !== 1'b1) begin
      errors++;
      $display("FAIL timeout: got cycle=%0d done=%b err=%b expected cycle=%0d done=0 err=1",
               at, d, er, base + S_REL + GRD + 1 + TMO);
    end
    @(negedge refclk);
    checks++;
    if (cfg_busy !== 1'b0 || cfg_error !== 1'b1 || cfg_done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_after: got busy=%b err=%b done=%b expected 0 1 0", cfg_busy, cfg_error, cfg_done);
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL timeout_sb: got %0d pending expected 0", sb.size()); end
  endtask

  task automatic test_lock_at_timeout;
    int base, at;
    logic d, er;
    pll_locked = 1'b0;
    start_cfg(base);
    push_writes(base, 0);
    @(negedge refclk);
    checks++;
    if (cfg_error !== 1'b0) begin errors++; $display("FAIL error_cleared: got %b expected 0", cfg_error); end
    wait_cycle(base + S_REL + GRD + TMO);
    pll_locked = 1'b1;
    wait_end(50, at, d, er);
    checks++;
    if (at != base + S_REL + GRD + 1 + TMO || d !== 1'b1 || er !== 1'b0) begin
      errors++;
      $display("FAIL lock_vs_timeout: got cycle=%0d done=%b err=%b expected cycle=%0d done=1 err=0",
               at, d, er, base + S_REL + GRD + 1 + TMO);
    end
  endtask

  task automatic test_start_on_fall;
    int base, at;
    logic d, er;
    repeat (2) @(posedge refclk);
    #1;
    cfg_start = 1'b1; pll_locked = 1'b0; base = cyc;
    @(posedge refclk); #1;
    cfg_start = 1'b0; pll_locked = 1'b1;
    push_writes(base, 0);
    @(negedge refclk);
    checks++;
    if (lock_lost !== 1'b0 || cfg_busy !== 1'b1) begin
      errors++; $display("FAIL start_on_fall: got lost=%b busy=%b expected 0 1", lock_lost, cfg_busy);
    end
    wait_end(200, at, d, er);
    checks++;
    if (at != base + S_REL + GRD + 2 || d !== 1'b1 || lock_lost !== 1'b0) begin
      errors++;
      $display("FAIL start_on_fall_done: got cycle=%0d done=%b lost=%b expected cycle=%0d done=1 lost=0",
               at, d, lock_lost, base + S_REL + GRD + 2);
    end
  endtask

  task automatic test_stall;
    int base, at;
    logic d, er;
    start_cfg(base);
    push_writes(base, 3);
    wait_cycle(base + 3);
    mgmt_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge refclk);
      checks++;
      if (mgmt_write !== 1'b1 || mgmt_address !== 6'h03 || mgmt_writedata !== {14'b0, cfg_n}) begin
        errors++;
        $display("FAIL stall_hold%0d: got wr=%b addr=%h data=%h expected 1 03 %h",
                 i, mgmt_write, mgmt_address, mgmt_writedata, {14'b0, cfg_n});
      end
      @(posedge refclk); #1;
      if (i == 2) mgmt_waitrequest = 1'b0;
    end
    wait_end(200, at, d, er);
    checks++;
    if (at != base + S_REL + 3 + GRD + 2 || d !== 1'b1) begin
      errors++;
      $display("FAIL stall_done: got cycle=%0d done=%b expected cycle=%0d done=1", at, d, base + S_REL + 3 + GRD + 2);
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL stall_sb: got %0d pending expected 0", sb.size()); end
  endtask

  task automatic test_reset_mid;
    int base;
    start_cfg(base);
    push_writes(base, 0);
    wait_cycle(base + 4);
    @(negedge refclk);
    checks++;
    if (mgmt_write !== 1'b1 || mgmt_address !== 6'h05) begin
      errors++; $display("FAIL mid_wr_c: got wr=%b addr=%h expected 1 05", mgmt_write, mgmt_address);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cfg_busy, cfg_done, cfg_error, lock_lost, mgmt_write} !== 5'b0 ||
        mgmt_address !== 6'h0 || mgmt_writedata !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got flags=%b addr=%h data=%h expected 00000 00 0",
               {cfg_busy, cfg_done, cfg_error, lock_lost, mgmt_write}, mgmt_address, mgmt_writedata);
    end
    sb.delete();
    repeat (2) @(posedge refclk);
    #1 rst_n = 1'b1;
    repeat (30) @(negedge refclk);
    checks++;
    if (cfg_busy !== 1'b0 || mgmt_write !== 1'b0) begin
      errors++; $display("FAIL no_resume: got busy=%b wr=%b expected 0 0", cfg_busy, mgmt_write);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_lock_lost();
    test_timeout();
    test_lock_at_timeout();
    test_start_on_fall();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
